// File: rtl/rle_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rle_ctl : capture controller for an RLE encoder. Latches the encoder       |
// |           config on arm, gates/counts upstream samples, sequences flush.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rle_ctl #(
  parameter int DW        = 32,
  parameter int KW        = DW / 8,
  parameter int CW        = 32,
  parameter int FLUSH_CYC = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_enable,
  input  logic [1:0]    cfg_mode,
  input  logic [KW-1:0] cfg_groups,
  input  logic [CW-1:0] cfg_limit,
  input  logic          cmd_arm,
  input  logic          cmd_abort,
  input  logic          sti_valid,
  output logic          sti_ready,
  output logic          enc_enable,
  output logic [1:0]    enc_mode,
  output logic [KW-1:0] enc_groups,
  output logic          enc_arm,
  output logic          enc_valid,
  output logic          enc_flush,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] smp_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          enable_q, enable_d;
  logic [1:0]    mode_q, mode_d;
  logic [KW-1:0] groups_q, groups_d;
  logic [CW-1:0] limit_q, limit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [7:0]    fl_q, fl_d;
  logic          arm_q, arm_d;
  logic          ready_q, ready_d;
  logic          flush_q, flush_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;

  assign accept  = sti_valid & ready_q;
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    mode_d   = mode_q;
    groups_d = groups_q;
    limit_d  = limit_q;
    cnt_d    = cnt_q;
    fl_d     = fl_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // abort beats arm when both arrive together
        if (cmd_arm && !cmd_abort) begin
          enable_d = cfg_enable;
          mode_d   = cfg_mode;
          groups_d = cfg_groups;
          limit_d  = cfg_limit;
          cnt_d    = '0;
          state_d  = S_ARMED;
        end
      end
      S_ARMED: state_d = cmd_abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (accept) cnt_d = cnt_inc;
        if (cmd_abort || (accept && (limit_q != '0) && (cnt_inc == limit_q))) begin
          state_d = S_FLUSH;
          fl_d    = '0;
        end
      end
      S_FLUSH: begin
        if (fl_q == 8'(FLUSH_CYC - 1)) state_d = S_DONE;
        else                           fl_d    = fl_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // status outputs are registered, decoded from the next state
    ready_d = (state_d == S_RUN);
    arm_d   = (state_d == S_ARMED);
    busy_d  = (state_d == S_ARMED) || (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d  = (state_d == S_DONE);
    flush_d = (state_d == S_FLUSH) && (state_q != S_FLUSH) && enable_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      enable_q <= 1'b0;
      mode_q   <= '0;
      groups_q <= '0;
      limit_q  <= '0;
      cnt_q    <= '0;
      fl_q     <= '0;
      arm_q    <= 1'b0;
      ready_q  <= 1'b0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      groups_q <= groups_d;
      limit_q  <= limit_d;
      cnt_q    <= cnt_d;
      fl_q     <= fl_d;
      arm_q    <= arm_d;
      ready_q  <= ready_d;
      flush_q  <= flush_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sti_ready  = ready_q;
  assign enc_valid  = accept;
  assign enc_enable = enable_q;
  assign enc_mode   = mode_q;
  assign enc_groups = groups_q;
  assign enc_arm    = arm_q;
  assign enc_flush  = flush_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign smp_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rle_ctl.sv
`default_nettype none
// tb_rle_ctl : directed scenarios plus randomized traffic, every cycle compared
// against a phase-level reference model of the capture controller.
module tb_rle_ctl;
  localparam int DW        = 32;
  localparam int KW        = 4;
  localparam int CW        = 8;
  localparam int FLUSH_CYC = 4;
  localparam int CNT_MAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [KW-1:0] cfg_groups = '0;
  logic [CW-1:0] cfg_limit = '0;
  logic          cmd_arm = 1'b0, cmd_abort = 1'b0, sti_valid = 1'b0;
  logic          sti_ready, enc_enable, enc_arm, enc_valid, enc_flush, busy, done;
  logic [1:0]    enc_mode;
  logic [KW-1:0] enc_groups;
  logic [CW-1:0] smp_cnt;

  always #5 clk = ~clk;

  rle_ctl #(.DW(DW), .KW(KW), .CW(CW), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_groups(cfg_groups), .cfg_limit(cfg_limit),
    .cmd_arm(cmd_arm), .cmd_abort(cmd_abort), .sti_valid(sti_valid), .sti_ready(sti_ready),
    .enc_enable(enc_enable), .enc_mode(enc_mode), .enc_groups(enc_groups),
    .enc_arm(enc_arm), .enc_valid(enc_valid), .enc_flush(enc_flush),
    .busy(busy), .done(done), .smp_cnt(smp_cnt)
  );

  // reference model: capture phase plus remaining flush cycles
  typedef enum int {M_IDLE, M_ARMED, M_RUN, M_FLUSH, M_DONE} mphase_e;
  mphase_e       m_ph;
  int            m_fl_left, m_cnt, m_lim;
  logic          m_en;
  logic [1:0]    m_mode;
  logic [KW-1:0] m_grp;

  logic          nx_en = 1'b0;
  logic [1:0]    nx_mode = '0;
  logic [KW-1:0] nx_grp = '0;
  logic [CW-1:0] nx_lim = '0;

  int n_checks = 0, n_errors = 0;
  int n_valid = 0, n_flush = 0, n_ready = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_fl_left = 0; m_cnt = 0; m_lim = 0;
    m_en = 1'b0; m_mode = '0; m_grp = '0;
  endtask

  task automatic model_step();
    case (m_ph)
      M_IDLE, M_DONE:
        if (cmd_arm && !cmd_abort) begin
          m_en = cfg_enable; m_mode = cfg_mode; m_grp = cfg_groups; m_lim = int'(cfg_limit);
          m_cnt = 0; m_ph = M_ARMED;
        end
      M_ARMED: m_ph = cmd_abort ? M_IDLE : M_RUN;
      M_RUN: begin
        if (sti_valid) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        if (cmd_abort || (sti_valid && m_lim != 0 && m_cnt == m_lim)) begin
          m_ph = M_FLUSH; m_fl_left = FLUSH_CYC;
        end
      end
      M_FLUSH: begin
        m_fl_left--;
        if (m_fl_left == 0) m_ph = M_DONE;
      end
      default: m_ph = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    logic run_now;
    run_now = (m_ph == M_RUN) && rst;
    check_val("sti_ready", 64'(sti_ready), 64'(run_now));
    check_val("enc_valid", 64'(enc_valid), 64'(run_now && sti_valid));
    check_val("enc_arm", 64'(enc_arm), 64'(m_ph == M_ARMED));
    check_val("enc_flush", 64'(enc_flush), 64'(m_ph == M_FLUSH && m_fl_left == FLUSH_CYC && m_en));
    check_val("busy", 64'(busy), 64'(m_ph == M_ARMED || m_ph == M_RUN || m_ph == M_FLUSH));
    check_val("done", 64'(done), 64'(m_ph == M_DONE));
    check_val("enc_enable", 64'(enc_enable), 64'(m_en));
    check_val("enc_mode", 64'(enc_mode), 64'(m_mode));
    check_val("enc_groups", 64'(enc_groups), 64'(m_grp));
    check_val("smp_cnt", 64'(smp_cnt), 64'(m_cnt));
  endtask

  task automatic cyc(input logic arm, input logic abort, input logic sv);
    @(negedge clk);
    cmd_arm = arm; cmd_abort = abort; sti_valid = sv;
    cfg_enable = nx_en; cfg_mode = nx_mode; cfg_groups = nx_grp; cfg_limit = nx_lim;
    #1;
    compare_all();
    if (enc_valid) n_valid++;
    if (enc_flush) n_flush++;
    if (sti_ready) n_ready++;
    @(posedge clk);
    model_step();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    cmd_arm = 1'b0; cmd_abort = 1'b0;
    @(negedge clk);
    #1 compare_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_cfg(input logic en, input logic [1:0] md, input logic [KW-1:0] gr, input int lim);
    nx_en = en; nx_mode = md; nx_grp = gr; nx_lim = CW'(lim);
  endtask

  initial begin
    model_reset();
    #3 compare_all();
    @(negedge clk);
    rst = 1'b1;

    // limit 4, encoder disabled, continuous valid
    set_cfg(1'b0, 2'd1, 4'b0101, 4);
    n_valid = 0; n_flush = 0;
    cyc(1'b1, 1'b0, 1'b1);
    repeat (12) cyc(1'b0, 1'b0, 1'b1);
    check_val("lim4_valids", 64'(n_valid), 64'd4);
    check_val("lim4_flush", 64'(n_flush), 64'd0);
    check_val("lim4_done", 64'(done), 64'd1);
    check_val("lim4_cnt", 64'(smp_cnt), 64'd4);

    // unlimited, 10 samples then abort on the 10th
    set_cfg(1'b1, 2'd2, 4'b1110, 0);
    n_valid = 0; n_flush = 0;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (9) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    check_val("abort_cnt", 64'(smp_cnt), 64'd10);
    check_val("abort_flush", 64'(n_flush), 64'd1);
    check_val("abort_mode", 64'(enc_mode), 64'd2);
    check_val("abort_groups", 64'(enc_groups), 64'b1110);
    check_val("abort_done", 64'(done), 64'd1);

    // config changes during RUN are ignored
    set_cfg(1'b1, 2'd1, 4'b0011, 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    set_cfg(1'b0, 2'd3, 4'b1100, 2);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    check_val("shadow_mode", 64'(enc_mode), 64'd1);
    check_val("shadow_groups", 64'(enc_groups), 64'b0011);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);

    // abort while ARMED
    n_ready = 0;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    check_val("armabort_ready", 64'(n_ready), 64'd0);
    check_val("armabort_done", 64'(done), 64'd0);
    check_val("armabort_busy", 64'(busy), 64'd0);

    // simultaneous arm+abort in IDLE does nothing
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_val("armabort_same", 64'(busy), 64'd0);

    // toggling valid with limit 3
    set_cfg(1'b1, 2'd0, 4'b0000, 3);
    n_valid = 0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, (i % 2) == 0);
    check_val("lim3_valids", 64'(n_valid), 64'd3);
    check_val("lim3_cnt", 64'(smp_cnt), 64'd3);

    // reset during RUN, then restart
    set_cfg(1'b1, 2'd3, 4'b1010, 0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    async_reset();
    check_val("rst_cnt", 64'(smp_cnt), 64'd0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check_val("restart_cnt", 64'(smp_cnt), 64'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);

    // counter saturation
    set_cfg(1'b0, 2'd0, 4'b0000, 0);
    cyc(1'b1, 1'b0, 1'b1);
    repeat (CNT_MAX + 20) cyc(1'b0, 1'b0, 1'b1);
    check_val("sat_cnt", 64'(smp_cnt), 64'(CNT_MAX));
    cyc(1'b0, 1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_cfg(1'($urandom), 2'($urandom), KW'($urandom),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7)));
      if (i % 700 == 350) async_reset();
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rle_ctl.md
RLE_CTL -- requirements
Module: rle_ctl

Interface
REQ-001 Parameter DW, default 32, sample data width in bits.
REQ-002 Parameter KW, default DW/8, number of byte groups.
REQ-003 Parameter CW, default 32, sample-counter width.
REQ-004 Parameter FLUSH_CYC, default 4, FLUSH state length in cycles (legal range 1..255).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 cfg_enable  input  1  RLE enable request.
REQ-008 cfg_mode  input  2  RLE mode request.
REQ-009 cfg_groups  input  KW  disabled-group mask request.
REQ-010 cfg_limit  input  CW  samples per capture; 0 means unlimited.
REQ-011 cmd_arm  input  1  single-cycle start-capture command.
REQ-012 cmd_abort  input  1  single-cycle stop-capture command.
REQ-013 sti_valid  input  1  upstream sample valid.
REQ-014 sti_ready  output  1  upstream ready.
REQ-015 enc_enable, enc_mode[1:0], enc_groups[KW-1:0]  outputs  encoder configuration (enable, rle_mode, disabledGroups).
REQ-016 enc_arm  output  1  encoder arm pulse.
REQ-017 enc_valid  output  1  gated sample valid to encoder.
REQ-018 enc_flush  output  1  encoder pending-run flush pulse.
REQ-019 busy, done  outputs  1 each  status.
REQ-020 smp_cnt  output  CW  samples accepted in current capture.

Function
REQ-021 FSM states SHALL be IDLE, ARMED, RUN, FLUSH, DONE.
REQ-022 In IDLE or DONE, cmd_arm SHALL latch cfg_enable/cfg_mode/cfg_groups/cfg_limit into shadow registers, clear smp_cnt, and enter ARMED next cycle.
REQ-023 cfg_* changes outside the arm cycle SHALL have no effect; enc_enable/enc_mode/enc_groups SHALL drive shadow values continuously from arm until next arm or reset.
REQ-024 ARMED SHALL last exactly one cycle with enc_arm=1, then enter RUN; enc_arm SHALL be 0 in every other state.
REQ-025 sti_ready SHALL be 1 only in RUN; enc_valid SHALL equal sti_valid AND sti_ready combinationally.
REQ-026 Each cycle with enc_valid=1 SHALL increment smp_cnt by 1, saturating at 2^CW-1.
REQ-027 When cfg_limit≠0 and an accepted sample makes smp_cnt equal cfg_limit, the FSM SHALL enter FLUSH next cycle, so sti_ready is 0 from that cycle on.
REQ-028 cmd_abort in RUN SHALL enter FLUSH next cycle; a sample accepted in the abort cycle SHALL be counted and forwarded.
REQ-029 cmd_abort in ARMED SHALL return to IDLE with enc_arm still pulsed once and no RUN cycle.
REQ-030 cmd_abort in IDLE, FLUSH or DONE SHALL be ignored; cmd_arm in ARMED, RUN or FLUSH SHALL be ignored.
REQ-031 Simultaneous cmd_arm and cmd_abort in IDLE or DONE SHALL leave state unchanged (abort wins).
REQ-032 FLUSH SHALL last exactly FLUSH_CYC cycles, then enter DONE.
REQ-033 enc_flush SHALL be 1 on the first FLUSH cycle only, and only if latched enable=1.
REQ-034 DONE SHALL hold done=1 until cmd_arm; busy SHALL be 1 in ARMED, RUN and FLUSH only.
REQ-035 smp_cnt SHALL hold its final value in FLUSH and DONE.

Reset
REQ-036 rst low SHALL asynchronously force IDLE, all shadow registers to 0, smp_cnt=0, and every output to 0.
REQ-037 Reset asserted mid-capture SHALL abort without enc_flush; first post-reset state SHALL be IDLE.

Verification
REQ-038 cfg_limit=4, enable=0, arm, sti_valid constant 1 -> enc_arm one cycle, exactly 4 enc_valid cycles, no enc_flush, FLUSH 4 cycles, done=1, smp_cnt=4.
REQ-039 cfg_limit=0, enable=1, mode=2, groups=4'b1110, 10 samples then cmd_abort -> enc_enable=1, enc_mode=2, enc_groups=4'b1110 stable, smp_cnt=10, single enc_flush pulse, done.
REQ-040 Arm, then change cfg_mode and cfg_groups during RUN -> enc_mode/enc_groups unchanged until next arm.
REQ-041 cmd_abort in ARMED cycle -> back to IDLE, sti_ready never 1, done=0.
REQ-042 sti_valid toggling 1/0 with cfg_limit=3 -> sti_ready falls on cycle after third accepted sample; no fourth enc_valid.
REQ-043 rst low during RUN -> all outputs 0 immediately; cmd_arm after release restarts with smp_cnt=0.
